// File: rtl/wb_write_arbiter_if.sv
// rtl/wb_write_arbiter_if.sv - writeback arbiter bus bundle (bypass ports under WB_BYPASS_EN)
interface wb_write_arbiter_if;
    logic        pipe_we;
    logic [4:0]  pipe_w;
    logic [31:0] pipe_din;
    logic        lu_valid;
    logic        lu_ready;
    logic [4:0]  lu_w;
    logic [31:0] lu_din;
    logic        rf_we;
    logic [4:0]  rf_w;
    logic [31:0] rf_din;
    logic [31:0] busy_mask;
    logic        stall_req;
`ifdef WB_BYPASS_EN
    logic [4:0]  q1_addr;
    logic [4:0]  q2_addr;
    logic        q1_hit;
    logic        q2_hit;
    logic [31:0] q1_data;
    logic [31:0] q2_data;

    modport slave (
        input  pipe_we, pipe_w, pipe_din, lu_valid, lu_w, lu_din, q1_addr, q2_addr,
        output lu_ready, rf_we, rf_w, rf_din, busy_mask, stall_req,
               q1_hit, q2_hit, q1_data, q2_data
    );
    modport master (
        output pipe_we, pipe_w, pipe_din, lu_valid, lu_w, lu_din, q1_addr, q2_addr,
        input  lu_ready, rf_we, rf_w, rf_din, busy_mask, stall_req,
               q1_hit, q2_hit, q1_data, q2_data
    );
`else
    modport slave (
        input  pipe_we, pipe_w, pipe_din, lu_valid, lu_w, lu_din,
        output lu_ready, rf_we, rf_w, rf_din, busy_mask, stall_req
    );
    modport master (
        output pipe_we, pipe_w, pipe_din, lu_valid, lu_w, lu_din,
        input  lu_ready, rf_we, rf_w, rf_din, busy_mask, stall_req
    );
`endif
endinterface

// File: rtl/wb_write_arbiter.sv
// rtl/wb_write_arbiter.sv - register-file write port arbiter, pipe priority, buffered long-latency source (optional bypass: WB_BYPASS_EN)
module wb_write_arbiter #(
    parameter int DEPTH    = 2,
    parameter int MAX_WAIT = 8
) (
    input  logic               CLK,
    input  logic               RST,
    wb_write_arbiter_if.slave  bus
);
    localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int CW = $clog2(DEPTH + 1);
    localparam int WW = $clog2(MAX_WAIT + 1);

    logic [4:0]    fifo_w [DEPTH];
    logic [31:0]   fifo_d [DEPTH];
    logic [AW-1:0] rd_ptr;
    logic [AW-1:0] wr_ptr;
    logic [CW-1:0] count;
    logic [WW-1:0] wait_cnt;
    logic          rf_we_q;
    logic [4:0]    rf_w_q;
    logic [31:0]   rf_din_q;

    logic pe;
    logic ready;
    logic push;
    logic pop;

    // Pipe always wins; the buffer head drains only on cycles the pipe leaves free.
    // A zero-destination LU result still handshakes but is dropped.
    assign pe    = bus.pipe_we && (bus.pipe_w != 5'd0);
    assign ready = (count < CW'(DEPTH));
    assign push  = bus.lu_valid && ready && (bus.lu_w != 5'd0);
    assign pop   = !pe && (count != '0);

    assign bus.lu_ready  = ready;
    assign bus.rf_we     = rf_we_q;
    assign bus.rf_w      = rf_w_q;
    assign bus.rf_din    = rf_din_q;
    assign bus.stall_req = (wait_cnt == WW'(MAX_WAIT));

    // Output register, FIFO storage/pointers and head age counter.
    always_ff @(posedge CLK) begin
        if (RST) begin
            rf_we_q  <= 1'b0;
            rf_w_q   <= 5'd0;
            rf_din_q <= 32'd0;
            rd_ptr   <= '0;
            wr_ptr   <= '0;
            count    <= '0;
            wait_cnt <= '0;
        end else begin
            if (pe) begin
                rf_we_q  <= 1'b1;
                rf_w_q   <= bus.pipe_w;
                rf_din_q <= bus.pipe_din;
            end else if (pop) begin
                rf_we_q  <= 1'b1;
                rf_w_q   <= fifo_w[rd_ptr];
                rf_din_q <= fifo_d[rd_ptr];
            end else begin
                rf_we_q  <= 1'b0;
            end

            if (push) begin
                fifo_w[wr_ptr] <= bus.lu_w;
                fifo_d[wr_ptr] <= bus.lu_din;
                wr_ptr         <= wr_ptr + AW'(1);
            end
            if (pop) begin
                rd_ptr <= rd_ptr + AW'(1);
            end

            case ({push, pop})
                2'b10:   count <= count + CW'(1);
                2'b01:   count <= count - CW'(1);
                default: count <= count;
            endcase

            // Age counts only a head that was present and skipped this edge.
            if (pop || (count == '0)) begin
                wait_cnt <= '0;
            end else if (wait_cnt != WW'(MAX_WAIT)) begin
                wait_cnt <= wait_cnt + WW'(1);
            end
        end
    end

    // Scoreboard: one-hot destination of every valid buffered entry.
    always_comb begin
        bus.busy_mask = 32'd0;
        for (int i = 0; i < DEPTH; i++) begin
            if (CW'(i) < count) begin
                bus.busy_mask[fifo_w[rd_ptr + AW'(i)]] = 1'b1;
            end
        end
    end

`ifdef WB_BYPASS_EN
    logic [4:0]  q_addr [2];
    logic        q_hit  [2];
    logic [31:0] q_data [2];

    assign q_addr[0]   = bus.q1_addr;
    assign q_addr[1]   = bus.q2_addr;
    assign bus.q1_hit  = q_hit[0];
    assign bus.q2_hit  = q_hit[1];
    assign bus.q1_data = q_data[0];
    assign bus.q2_data = q_data[1];

    // Operand forwarding: scan oldest (output register) to youngest FIFO slot so the last match wins.
    always_comb begin
        for (int q = 0; q < 2; q++) begin
            q_hit[q]  = 1'b0;
            q_data[q] = 32'd0;
            if (q_addr[q] != 5'd0) begin
                if (rf_we_q && (rf_w_q == q_addr[q])) begin
                    q_hit[q]  = 1'b1;
                    q_data[q] = rf_din_q;
                end
                for (int i = 0; i < DEPTH; i++) begin
                    if ((CW'(i) < count) && (fifo_w[rd_ptr + AW'(i)] == q_addr[q])) begin
                        q_hit[q]  = 1'b1;
                        q_data[q] = fifo_d[rd_ptr + AW'(i)];
                    end
                end
            end
        end
    end
`endif
endmodule

// File: tb/tb_wb_write_arbiter.sv
// tb/tb_wb_write_arbiter.sv - self-checking bench for wb_write_arbiter against a queue-based reference
module tb_wb_write_arbiter;
    localparam int DEPTH    = 2;
    localparam int MAX_WAIT = 8;

    typedef struct {
        logic [4:0]  w;
        logic [31:0] d;
    } ent_t;

    logic CLK = 1'b0;
    logic RST;
    always #5 CLK = ~CLK;

    wb_write_arbiter_if bus ();

    wb_write_arbiter #(.DEPTH(DEPTH), .MAX_WAIT(MAX_WAIT)) dut (
        .CLK (CLK),
        .RST (RST),
        .bus (bus)
    );

    int passed = 0;
    int total  = 0;

    ent_t        q[$];
    logic        m_we;
    logic [4:0]  m_w;
    logic [31:0] m_d;
    int          m_wait;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) passed++;
        else $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    endtask

    function automatic logic [31:0] m_busy();
        logic [31:0] m;
        m = 32'd0;
        foreach (q[i]) m[q[i].w] = 1'b1;
        return m;
    endfunction

`ifdef WB_BYPASS_EN
    task automatic m_lookup(input logic [4:0] a, output logic hit, output logic [31:0] d);
        hit = 1'b0;
        d   = 32'd0;
        if (a != 5'd0) begin
            if (m_we && m_w == a) begin
                hit = 1'b1;
                d   = m_d;
            end
            foreach (q[i]) if (q[i].w == a) begin
                hit = 1'b1;
                d   = q[i].d;
            end
        end
    endtask
`endif

    task automatic check_outputs(input string tag);
        chk({tag, "_rf_we"}, 32'(bus.rf_we), 32'(m_we));
        chk({tag, "_rf_w"}, 32'(bus.rf_w), 32'(m_w));
        chk({tag, "_rf_din"}, bus.rf_din, m_d);
        chk({tag, "_busy"}, bus.busy_mask, m_busy());
        chk({tag, "_stall"}, 32'(bus.stall_req), 32'(m_wait == MAX_WAIT));
        chk({tag, "_no_w0"}, 32'(bus.rf_we && bus.rf_w == 5'd0), 32'd0);
    endtask

    // Apply the currently driven inputs across one edge, advancing the model by the arbitration rules.
    task automatic cycle(input string tag);
        logic rdy;
        logic pe;
        logic popped;
        int   old_size;
        ent_t e;
`ifdef WB_BYPASS_EN
        logic        h;
        logic [31:0] hd;
        bus.q1_addr = 5'($urandom_range(0, 31));
        bus.q2_addr = (q.size() > 0) ? q[q.size()-1].w : m_w;
        #1;
        m_lookup(bus.q1_addr, h, hd);
        chk({tag, "_q1_hit"}, 32'(bus.q1_hit), 32'(h));
        chk({tag, "_q1_data"}, bus.q1_data, hd);
        m_lookup(bus.q2_addr, h, hd);
        chk({tag, "_q2_hit"}, 32'(bus.q2_hit), 32'(h));
        chk({tag, "_q2_data"}, bus.q2_data, hd);
`endif
        rdy = (q.size() < DEPTH);
        chk({tag, "_lu_ready"}, 32'(bus.lu_ready), 32'(rdy));
        if (RST) begin
            q.delete();
            m_we = 1'b0; m_w = 5'd0; m_d = 32'd0; m_wait = 0;
        end else begin
            old_size = q.size();
            pe       = bus.pipe_we && bus.pipe_w != 5'd0;
            popped   = 1'b0;
            if (pe) begin
                m_we = 1'b1; m_w = bus.pipe_w; m_d = bus.pipe_din;
            end else if (old_size > 0) begin
                e = q.pop_front();
                m_we = 1'b1; m_w = e.w; m_d = e.d;
                popped = 1'b1;
            end else begin
                m_we = 1'b0;
            end
            if (popped || old_size == 0) m_wait = 0;
            else if (m_wait < MAX_WAIT) m_wait++;
            if (bus.lu_valid && rdy && bus.lu_w != 5'd0) q.push_back('{bus.lu_w, bus.lu_din});
        end
        @(posedge CLK);
        #1;
        check_outputs(tag);
    endtask

    task automatic set_idle();
        RST = 1'b0;
        bus.pipe_we = 1'b0; bus.pipe_w = 5'd0; bus.pipe_din = 32'd0;
        bus.lu_valid = 1'b0; bus.lu_w = 5'd0; bus.lu_din = 32'd0;
    endtask

    task automatic set_pipe(input logic en, input logic [4:0] w, input logic [31:0] d);
        bus.pipe_we = en; bus.pipe_w = w; bus.pipe_din = d;
    endtask

    task automatic set_lu(input logic v, input logic [4:0] w, input logic [31:0] d);
        bus.lu_valid = v; bus.lu_w = w; bus.lu_din = d;
    endtask

    initial begin
        set_idle();
`ifdef WB_BYPASS_EN
        bus.q1_addr = 5'd0;
        bus.q2_addr = 5'd0;
`endif
        q.delete();
        m_we = 1'b0; m_w = 5'd0; m_d = 32'd0; m_wait = 0;

        // Reset, then idle.
        RST = 1'b1;
        @(posedge CLK);
        #1;
        cycle("rst");
        RST = 1'b0;
        for (int i = 0; i < 3; i++) cycle("idle");
        chk("idle_rf_we_const", 32'(bus.rf_we), 32'd0);
        chk("idle_ready_const", 32'(bus.lu_ready), 32'd1);

        // Single pipe write.
        set_pipe(1'b1, 5'd5, 32'hDEADBEEF);
        cycle("pipe1");
        chk("pipe1_din_const", bus.rf_din, 32'hDEADBEEF);
        set_pipe(1'b0, 5'd0, 32'd0);
        cycle("pipe1_after");
        chk("pipe1_after_we_const", 32'(bus.rf_we), 32'd0);

        // Pipe saturates the port while two LU results queue up and age.
        set_pipe(1'b1, 5'd1, 32'h100);
        set_lu(1'b1, 5'd7, 32'h11);
        cycle("fill_a");
        set_pipe(1'b1, 5'd2, 32'h101);
        set_lu(1'b1, 5'd9, 32'h22);
        cycle("fill_b");
        chk("fill_busy_const", bus.busy_mask, 32'h280);
        chk("fill_ready_const", 32'(bus.lu_ready), 32'd0);
        set_lu(1'b0, 5'd0, 32'd0);
        for (int i = 0; i < 7; i++) begin
            set_pipe(1'b1, 5'(i + 10), 32'(i));
            cycle("age");
        end
        chk("age_stall_const", 32'(bus.stall_req), 32'd1);
        set_pipe(1'b1, 5'd20, 32'h55);
        cycle("stall_ignored");
        set_pipe(1'b0, 5'd0, 32'd0);
        cycle("pop7");
        chk("pop7_w_const", 32'(bus.rf_w), 32'd7);
        cycle("pop9");
        chk("pop9_w_const", 32'(bus.rf_w), 32'd9);
        chk("pop9_busy_const", bus.busy_mask, 32'd0);
        cycle("drained");

        // Zero-destination LU result handshakes but is dropped.
        set_lu(1'b1, 5'd0, 32'hBAD);
        cycle("lu_w0");
        set_lu(1'b0, 5'd0, 32'd0);
        cycle("lu_w0_after");

        // Simultaneous pipe write and LU push into an empty FIFO.
        set_pipe(1'b1, 5'd3, 32'h33);
        set_lu(1'b1, 5'd4, 32'h44);
        cycle("sim_e1");
        chk("sim_e1_w_const", 32'(bus.rf_w), 32'd3);
        set_idle();
        cycle("sim_e2");
        chk("sim_e2_w_const", 32'(bus.rf_w), 32'd4);
        cycle("sim_idle");

        // Reset with two buffered entries discards them.
        set_pipe(1'b1, 5'd1, 32'h1);
        set_lu(1'b1, 5'd7, 32'h77);
        cycle("rfill_a");
        set_lu(1'b1, 5'd9, 32'h99);
        cycle("rfill_b");
        set_idle();
        RST = 1'b1;
        cycle("rst_mid");
        chk("rst_mid_busy_const", bus.busy_mask, 32'd0);
        RST = 1'b0;
        for (int i = 0; i < 3; i++) cycle("rst_after");

        // Randomized traffic, upstream mostly honouring stall_req.
        for (int i = 0; i < 400; i++) begin
            RST = ($urandom_range(0, 99) == 0);
            bus.pipe_we  = bus.stall_req ? ($urandom_range(0, 9) == 0) : 1'($urandom_range(0, 1));
            bus.pipe_w   = 5'($urandom_range(0, 31));
            bus.pipe_din = $urandom;
            bus.lu_valid = 1'($urandom_range(0, 1));
            bus.lu_w     = ($urandom_range(0, 7) == 0) ? 5'd0 : 5'($urandom_range(1, 31));
            bus.lu_din   = $urandom;
            cycle("rand");
        end

        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end
endmodule
